// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals shared by the arbiter.
// Handshake: x_req is held until the one-cycle x_ready pulse; mem_valid is held until mem_ready.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    output if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    input  if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store requesters,
// latching the granted payload and aborting transactions that exceed a cycle budget.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit ROUND_ROBIN    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t         state;
  logic           last_grant;
  logic [CW-1:0]  cnt;
  logic           mem_valid;
  logic           mem_we;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [3:0]     mem_wstrb;

  logic expired;
  logic done;
  logic grant_d;
  logic i_done;
  logic d_done;

  // Expiry is only seen one cycle after the budget is used up, so a
  // mem_ready arriving on the last budgeted cycle still completes normally.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);
  assign done    = bus.mem_ready || expired;
  assign grant_d = bus.d_req && (!bus.if_req || !ROUND_ROBIN || (last_grant == GRANT_I));
  assign i_done  = (state == BUSY_I) && done;
  assign d_done  = (state == BUSY_D) && done;

  assign bus.if_ready  = i_done;
  assign bus.if_err    = i_done && expired;
  assign bus.if_rdata  = (i_done && !expired) ? bus.mem_rdata : 32'h0;
  assign bus.d_ready   = d_done;
  assign bus.d_err     = d_done && expired;
  assign bus.d_rdata   = (d_done && !expired) ? bus.mem_rdata : 32'h0;

  assign bus.mem_valid = mem_valid;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_wstrb = mem_wstrb;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      cnt        <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant_d) begin
            state      <= BUSY_D;
            last_grant <= GRANT_D;
            mem_valid  <= 1'b1;
            mem_we     <= bus.d_we;
            mem_addr   <= bus.d_addr;
            mem_wdata  <= bus.d_wdata;
            mem_wstrb  <= bus.d_we ? bus.d_wstrb : 4'h0;
          end else if (bus.if_req) begin
            state      <= BUSY_I;
            last_grant <= GRANT_I;
            mem_valid  <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= bus.if_addr;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'h0;
          end
        end
        default: begin
          if (done) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scoreboarded fetch/load/store traffic against a
// latency-programmable memory model, plus tie-breaking, timeout and reset cases.
module tb_mem_port_arbiter;
  localparam int TMO = 4;
  localparam logic [31:0] K = 32'h8000_0013;

  logic clk;
  logic reset;
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  mem_port_arbiter_if ia();
  mem_port_arbiter_if ib();

  mem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .ROUND_ROBIN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(ia), .dbg_state(dbg_a)
  );

  mem_port_arbiter #(.TIMEOUT_CYCLES(0), .ROUND_ROBIN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(ib), .dbg_state(dbg_b)
  );

  // Memory behind dut_b answers in the first cycle of every transaction.
  assign ib.mem_ready = ib.mem_valid;
  assign ib.mem_rdata = ib.mem_addr ^ K;

  int n_checks = 0;
  int n_err    = 0;
  int mem_lat  = 1;
  int age      = 0;
  bit idle_noise_en = 1'b0;

  logic [70:0] pay_q[$];
  logic [33:0] exp_q[$];
  logic [70:0] cap;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // memory model for dut_a: mem_ready on the mem_lat-th BUSY cycle, never when mem_lat==0
  always @(posedge clk) begin
    #1;
    if (ia.mem_valid) age = age + 1;
    else age = 0;
    if (ia.mem_valid) begin
      ia.mem_ready = (mem_lat != 0) && (age == mem_lat);
      ia.mem_rdata = ia.mem_addr ^ K;
    end else begin
      ia.mem_ready = idle_noise_en && ($urandom_range(0, 1) == 1);
      ia.mem_rdata = $urandom;
    end
  end

  // scoreboard for dut_a
  always @(negedge clk) begin
    logic [70:0] cur;
    logic [33:0] res;
    if (reset) begin
      chk("one_ready", ia.if_ready & ia.d_ready, 0);
      chk("quiet_out", {(ia.if_ready ? 33'h0 : {ia.if_err, ia.if_rdata}),
                        (ia.d_ready ? 33'h0 : {ia.d_err, ia.d_rdata})}, 0);
      if (ia.mem_valid) begin
        cur = {dbg_a, ia.mem_addr, ia.mem_we, ia.mem_wdata, ia.mem_wstrb};
        if (age == 1) begin
          chk("grant_expected", pay_q.size() != 0, 1);
          if (pay_q.size() != 0) chk("grant", cur, pay_q.pop_front());
          cap = cur;
        end else begin
          chk("stable", cur, cap);
        end
      end
      if (ia.if_ready | ia.d_ready) begin
        res = ia.d_ready ? {1'b1, ia.d_err, ia.d_rdata} : {1'b0, ia.if_err, ia.if_rdata};
        chk("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("result", res, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic zero_inputs();
    ia.if_req = 0; ia.if_addr = 0; ia.d_req = 0; ia.d_we = 0;
    ia.d_addr = 0; ia.d_wdata = 0; ia.d_wstrb = 0;
    ib.if_req = 0; ib.if_addr = 0; ib.d_req = 0; ib.d_we = 0;
    ib.d_addr = 0; ib.d_wdata = 0; ib.d_wstrb = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    zero_inputs();
    pay_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic xact(input bit is_d, input logic [31:0] a, input bit we,
                      input logic [31:0] wd, input logic [3:0] ws, input int lat);
    bit to;
    bit seen;
    int exp_n;
    to = (lat == 0) || (lat > TMO);
    exp_n = to ? TMO + 1 : lat;
    mem_lat = lat;
    pay_q.push_back(is_d ? {2'd2, a, we, wd, (we ? ws : 4'h0)} : {2'd1, a, 1'b0, 32'h0, 4'h0});
    exp_q.push_back({is_d, to, (to ? 32'h0 : (a ^ K))});
    if (is_d) begin
      ia.d_req = 1; ia.d_we = we; ia.d_addr = a; ia.d_wdata = wd; ia.d_wstrb = ws;
    end else begin
      ia.if_req = 1; ia.if_addr = a;
    end
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (ia.if_ready | ia.d_ready) begin
        seen = 1;
        chk("latency", n, exp_n);
      end else begin
        @(posedge clk);
        #1;
        ia.if_addr = $urandom; ia.d_addr = $urandom; ia.d_wdata = $urandom;
        ia.d_wstrb = 4'($urandom); ia.d_we = 1'($urandom);
      end
    end
    if (!seen) chk("ready_seen", seen, 1);
    @(posedge clk);
    #1;
    ia.if_req = 0; ia.d_req = 0;
    @(negedge clk);
    chk("valid_drop", ia.mem_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    reset = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem", {ia.mem_valid, ia.mem_we, ia.mem_addr, ia.mem_wdata, ia.mem_wstrb}, 0);
    chk("reset_rdy", {ia.if_ready, ia.d_ready, ia.if_err, ia.d_err}, 0);
    chk("reset_state", dbg_a, 0);
    chk("reset_b", {ib.mem_valid, ib.if_ready, ib.d_ready, dbg_b}, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    xact(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1);
    xact(1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'h3, 3);
    xact(1'b1, 32'h8000_0104, 1'b0, 32'h1234_5678, 4'hF, 2);
    xact(1'b0, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 0);
    xact(1'b0, 32'h8000_0044, 1'b0, 32'h0, 4'h0, TMO);
    xact(1'b1, 32'h8000_0108, 1'b1, 32'h0BAD_F00D, 4'h5, 0);

    idle_noise_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      xact(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, TMO));
    end
    idle_noise_en = 1'b0;

    // reset while a store is outstanding
    mem_lat = 0;
    pay_q.push_back({2'd2, 32'h8000_0200, 1'b1, 32'hCAFE_F00D, 4'hC});
    ia.d_req = 1; ia.d_we = 1; ia.d_addr = 32'h8000_0200; ia.d_wdata = 32'hCAFE_F00D; ia.d_wstrb = 4'hC;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_valid", ia.mem_valid, 0);
    chk("midrst_dready", ia.d_ready, 0);
    chk("midrst_state", dbg_a, 0);
    ia.d_req = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    xact(1'b0, 32'h8000_0300, 1'b0, 32'h0, 4'h0, 2);

    // tie with round robin, fresh from reset: D, I, D, I
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 2; i++) begin
      pay_q.push_back({2'd2, 32'h0000_1000, 1'b1, 32'h1111_2222, 4'hF});
      exp_q.push_back({1'b1, 1'b0, 32'h0000_1000 ^ K});
      pay_q.push_back({2'd1, 32'h0000_2000, 1'b0, 32'h0, 4'h0});
      exp_q.push_back({1'b0, 1'b0, 32'h0000_2000 ^ K});
    end
    ia.d_we = 1; ia.d_addr = 32'h0000_1000; ia.d_wdata = 32'h1111_2222; ia.d_wstrb = 4'hF;
    ia.if_addr = 32'h0000_2000;
    ia.d_req = 1; ia.if_req = 1;
    seen = 0;
    for (int n = 0; n < 40 && seen < 4; n++) begin
      @(negedge clk);
      if (ia.if_ready | ia.d_ready) seen++;
    end
    chk("tie_count", seen, 4);
    @(posedge clk);
    #1;
    ia.d_req = 0; ia.if_req = 0;
    @(posedge clk);
    #1;

    // data-priority instance: fetch starves while d_req is held
    ib.if_addr = 32'h0000_2000; ib.d_addr = 32'h0000_1000; ib.d_we = 0;
    ib.if_req = 1; ib.d_req = 1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("rr0_dready", ib.d_ready, n[0]);
      chk("rr0_iready", ib.if_ready, 0);
      chk("rr0_drdata", ib.d_rdata, n[0] ? (32'h0000_1000 ^ K) : 32'h0);
    end
    @(posedge clk);
    #1 ib.d_req = 0;
    @(negedge clk);
    chk("rr0_iwait", ib.if_ready, 0);
    @(negedge clk);
    chk("rr0_ifetch", {ib.if_ready, ib.if_err, ib.if_rdata}, {1'b1, 1'b0, 32'h0000_2000 ^ K});
    @(posedge clk);
    #1 ib.if_req = 0;
    repeat (2) @(posedge clk);

    chk("pay_q_empty", pay_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory interface between the core's instruction-fetch requester and its load/store requester.
- Sits between the core datapath (fetch PC, load/store address/write data) and the memory/bus model.
- Serialises accesses and latches request payloads, so the memory side sees stable signals for the whole transaction.
- Arbitrates simultaneous requests and aborts any transaction whose memory response exceeds a cycle budget.

Parameters:
- TIMEOUT_CYCLES, 256, maximum BUSY cycles without mem_ready before abort; 0 disables the timeout.
- ROUND_ROBIN, 1, 1 = alternate grant on ties; 0 = data requester always wins ties.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  32  fetch address.
- if_ready  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  32  fetch data; valid only while if_ready=1.
- if_err  out  1  timeout flag; valid only while if_ready=1.
- d_req  in  1  load/store request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  load/store address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte enables; ignored for loads.
- d_ready  out  1  one-cycle completion pulse to load/store.
- d_rdata  out  32  load data; valid only while d_ready=1.
- d_err  out  1  timeout flag; valid only while d_ready=1.
- mem_valid  out  1  request to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte enables.
- mem_ready  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  memory read data.

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=INSTR, timeout counter=0.
  - mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb are all 0.
  - if_ready, d_ready, if_err, d_err are 0.
- IDLE grant rules, evaluated each cycle:
  - Only if_req=1: latch if_addr; mem_we=0, mem_wstrb=0, mem_wdata=0; next state BUSY_I.
  - Only d_req=1: latch d_addr, d_we, d_wdata, and d_wstrb (d_wstrb forced to 0 when d_we=0); next state BUSY_D.
  - Both requests: ROUND_ROBIN=1 grants the requester not in last_grant; ROUND_ROBIN=0 grants data.
  - last_grant updates on every grant.
- mem_* outputs are registered:
  - mem_valid=1 exactly while in a BUSY state.
  - mem_addr, mem_we, mem_wdata, mem_wstrb stay constant for the whole BUSY period.
- In BUSY_x with mem_ready=1:
  - x_ready=1 that cycle, combinational from mem_ready.
  - x_rdata=mem_rdata, x_err=0.
  - Next state IDLE; mem_valid=0 next cycle.
- mem_ready is ignored in IDLE.
- Latency: request seen in cycle N → mem_valid in N+1. The earliest x_ready is N+1 (mem_ready already high). Peak throughput is one transaction per 2 cycles, since IDLE always lasts at least 1 cycle.
- Outside their completion cycle, if_rdata and d_rdata drive 0.
- Timeout counter:
  - Cleared on entering BUSY; increments each BUSY cycle with mem_ready=0.
  - If it reaches TIMEOUT_CYCLES with mem_ready=0, the next cycle pulses x_ready=1 with x_err=1 and x_rdata=0, then returns to IDLE with mem_valid=0.
  - mem_ready arriving in the same cycle as expiry counts as normal completion (x_err=0).
- A requester dropping req mid-transaction does not cancel it: the transaction completes and ready still pulses. A requester that keeps req high after its ready is treated as a new request.
- Only one of if_ready/d_ready is ever high in a cycle.
- Reset asserted mid-transaction: immediate return to reset state, no ready pulse; memory must tolerate mem_valid dropping.

Test Plan:
- Fetch only: if_req=1, if_addr=0x8000_0000, mem_ready high from first BUSY cycle with mem_rdata=0x0000_0013 → mem_valid in cycle 1, if_ready=1 with if_rdata=0x0000_0013 in cycle 1, mem_valid=0 in cycle 2.
- Store: d_req=1, d_we=1, d_addr=0x8000_0100, d_wdata=0xDEADBEEF, d_wstrb=0x3, mem_ready after 3 cycles → mem_* fields stable for 3 cycles; d_ready pulses once, d_err=0.
- Tie, ROUND_ROBIN=1, after reset: both reqs held high → grant order D, I, D, I; ready pulses alternate, never both at once.
- ROUND_ROBIN=0 tie, with both held over repeated transactions → every grant goes to data; fetch waits until d_req=0.
- TIMEOUT_CYCLES=4, fetch with mem_ready stuck 0 → if_ready=1 with if_err=1, if_rdata=0, then IDLE. Then mem_ready=1 exactly at the 4th cycle → normal completion, if_err=0.
- Reset pulled low while in BUSY_D → mem_valid=0 immediately, no d_ready; after release, a new fetch completes normally.
